// File: rtl/haar_pkg.sv
// Shared types and helpers for the multirate Haar analysis scheduler.
// The rounding butterfly variant is selected with the HAAR_SCHED_ROUND_EN macro.
package haar_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WALK = 1'b1
  } state_t;

  localparam int unsigned MIN_SIDX_W = 1;

  // Stage-index width: enough bits to address STAGES levels, never zero.
  function automatic int unsigned sidx_width(input int unsigned stages);
    return (stages > 1) ? int'($clog2(stages)) : MIN_SIDX_W;
  endfunction

  // Output word that receives the high-pass result of stage s.
  function automatic int unsigned word_idx(input int unsigned stages, input int unsigned s);
    return stages - s;
  endfunction

endpackage

// File: rtl/haar_butterfly.sv
// Combinational Haar averaging/differencing butterfly, evaluated one bit wider than storage.
// HAAR_SCHED_ROUND_EN selects round-half-up instead of floor.
module haar_butterfly #(
  parameter int unsigned W = 18
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] lo,
  output logic signed [W-1:0] hi
);

  localparam int unsigned EW = W + 1;

`ifdef HAAR_SCHED_ROUND_EN
  localparam logic signed [EW-1:0] RND = EW'(1);
`else
  localparam logic signed [EW-1:0] RND = '0;
`endif

  logic signed [EW-1:0] sum;
  logic signed [EW-1:0] dif;

  always_comb begin
    sum = EW'(a) + EW'(b) + RND;
    dif = EW'(a) - EW'(b) + RND;
    lo  = W'(sum >>> 1);
    hi  = W'(dif >>> 1);
  end

endmodule

// File: rtl/haar_scheduler.sv
// Walks one shared Haar butterfly across all decimation stages per accepted sample.
// Build option: HAAR_SCHED_ROUND_EN (rounding butterfly, same timing).
module haar_scheduler
  import haar_pkg::*;
#(
  parameter int unsigned STAGES         = 4,
  parameter int unsigned IN_WIDTH       = 16,
  parameter int unsigned INTERNAL_WIDTH = 18,
  parameter int unsigned OUT_WIDTH      = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              inValid,
  output logic                              inReady,
  input  logic signed [IN_WIDTH-1:0]        inData,
  output logic                              busy,
  output logic [STAGES:0]                   outStrobes,
  output logic [OUT_WIDTH*(STAGES+1)-1:0]   dataOut
);

  localparam int unsigned NW     = STAGES + 1;
  localparam int unsigned SIDX_W = sidx_width(STAGES);
  localparam int unsigned DEPTH  = 1 << SIDX_W;
  localparam int unsigned LAST   = STAGES - 1;

  state_t state, state_nx;

  logic [SIDX_W-1:0]                s;
  logic [DEPTH-1:0]                 pend;
  logic signed [INTERNAL_WIDTH-1:0] cur;
  logic signed [INTERNAL_WIDTH-1:0] prev [DEPTH];
  logic signed [INTERNAL_WIDTH-1:0] bf_lo, bf_hi;
  logic [OUT_WIDTH-1:0]             words [NW];
  logic [NW-1:0]                    strobes;
  logic                             at_last;

  assign at_last = (s == SIDX_W'(LAST));

  haar_butterfly #(.W(INTERNAL_WIDTH)) u_bf (
    .a  (prev[s]),
    .b  (cur),
    .lo (bf_lo),
    .hi (bf_hi)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state: a walk ends at the first empty stage or after the last stage
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (inValid) state_nx = WALK;
      WALK: if (!pend[s] || at_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    inReady = 1'b0;
    busy    = 1'b0;
    case (state)
      IDLE:    inReady = 1'b1;
      WALK:    busy    = 1'b1;
      default: inReady = 1'b0;
    endcase
  end

  // Operand, per-stage history and published words
  always_ff @(posedge clk) begin
    if (rst) begin
      cur     <= '0;
      s       <= '0;
      pend    <= '0;
      strobes <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) prev[i] <= '0;
      for (int unsigned w = 0; w < NW; w++) words[w] <= '0;
    end else begin
      strobes <= '0;
      if (state == IDLE) begin
        if (inValid) begin
          cur <= INTERNAL_WIDTH'(inData);
          s   <= '0;
        end
      end else if (!pend[s]) begin
        prev[s] <= cur;
        pend[s] <= 1'b1;
      end else begin
        pend[s] <= 1'b0;
        for (int unsigned w = 0; w < NW; w++) begin
          if (w == word_idx(STAGES, 32'(s))) begin
            words[w]   <= OUT_WIDTH'(bf_hi);
            strobes[w] <= 1'b1;
          end
        end
        if (at_last) begin
          words[0]   <= OUT_WIDTH'(bf_lo);
          strobes[0] <= 1'b1;
        end else begin
          cur <= bf_lo;
          s   <= s + 1'b1;
        end
      end
    end
  end

  always_comb begin
    dataOut = '0;
    for (int unsigned w = 0; w < NW; w++) dataOut[w*OUT_WIDTH +: OUT_WIDTH] = words[w];
  end

  assign outStrobes = strobes;

endmodule

// File: tb/tb_haar_scheduler.sv
// Self-checking bench for haar_scheduler (STAGES=2) against a sample-level cascade model.
module tb_haar_scheduler;

  localparam int STAGES = 2;
  localparam int IN_W   = 16;
  localparam int INT_W  = 18;
  localparam int OUT_W  = 16;
  localparam int NW     = STAGES + 1;
  localparam int VW     = 2 + NW + OUT_W * NW;
`ifdef HAAR_SCHED_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  logic                  clk     = 1'b0;
  logic                  rst     = 1'b1;
  logic                  inValid = 1'b0;
  logic [IN_W-1:0]       inData  = '0;
  logic                  inReady;
  logic                  busy;
  logic [NW-1:0]         outStrobes;
  logic [OUT_W*NW-1:0]   dataOut;

  haar_scheduler #(
    .STAGES(STAGES), .IN_WIDTH(IN_W), .INTERNAL_WIDTH(INT_W), .OUT_WIDTH(OUT_W)
  ) dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady), .inData(inData),
    .busy(busy), .outStrobes(outStrobes), .dataOut(dataOut)
  );

  always #5 clk = ~clk;

  // Reference model: each accepted sample is pushed through the stage chain at once;
  // the resulting word updates are replayed one stage per cycle.
  int            m_pend [STAGES];
  int            m_prev [STAGES];
  int            m_word [NW];
  int            sch_val [STAGES+1][NW];
  logic [NW-1:0] sch_mask [STAGES+1];
  logic [NW-1:0] exp_strobe = '0;
  int            busy_left = 0;
  int            walk_off  = 0;
  int            n_cmp = 0, n_bad = 0, n_cyc = 0, n_acc = 0;
  logic [VW-1:0] obs, expv;

  task automatic model_accept(input int x);
    int c;
    c = x;
    for (int o = 0; o <= STAGES; o++) sch_mask[o] = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (m_pend[k] == 0) begin
        m_prev[k] = c;
        m_pend[k] = 1;
        busy_left = k + 1;
        break;
      end
      m_pend[k] = 0;
      sch_mask[k+1][STAGES-k] = 1'b1;
      sch_val[k+1][STAGES-k]  = (m_prev[k] - c + RND) >>> 1;
      if (k == STAGES - 1) begin
        sch_mask[k+1][0] = 1'b1;
        sch_val[k+1][0]  = (m_prev[k] + c + RND) >>> 1;
        busy_left = STAGES;
      end else begin
        c = (m_prev[k] + c + RND) >>> 1;
      end
    end
  endtask

  task automatic tick();
    bit acc;
    int x;
    acc = !rst && inValid && (busy_left == 0);
    x   = int'($signed(inData));
    @(posedge clk);
    #1;
    n_cyc++;
    exp_strobe = '0;
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin m_pend[k] = 0; m_prev[k] = 0; end
      for (int w = 0; w < NW; w++) m_word[w] = 0;
      busy_left = 0;
      walk_off  = 0;
    end else if (busy_left > 0) begin
      walk_off++;
      exp_strobe = sch_mask[walk_off];
      for (int w = 0; w < NW; w++)
        if (sch_mask[walk_off][w]) m_word[w] = sch_val[walk_off][w];
      busy_left--;
    end else if (acc) begin
      n_acc++;
      model_accept(x);
      walk_off = 0;
    end
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [OUT_W*NW-1:0] d;
    for (int w = 0; w < NW; w++) d[w*OUT_W +: OUT_W] = OUT_W'(m_word[w]);
    return {1'(busy_left == 0), 1'(busy_left > 0), exp_strobe, d};
  endfunction

  task automatic test_reset();
    rst = 1'b1; inValid = 1'b1; inData = 16'h1234;
    tick(); tick();
    rst = 1'b0; inValid = 1'b0;
    obs = {inReady, busy, outStrobes, dataOut}; expv = exp_vec(); n_cmp++;
    if (obs !== expv) begin n_bad++; $display("FAIL reset_state got=%h exp=%h", obs, expv); end
    n_cmp++;
    if (inReady !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", inReady); end
  endtask

  task automatic test_pairs();
    int xs [4];
    int a0, wt;
    logic [OUT_W-1:0] wv;
    xs[0] = 4; xs[1] = 2; xs[2] = 10; xs[3] = 6;
    for (int i = 0; i < 4; i++) begin
      inValid = 1'b1; inData = 16'(xs[i]); a0 = n_acc; wt = 0;
      while (n_acc == a0 && wt < 10) begin
        tick(); wt++;
        obs = {inReady, busy, outStrobes, dataOut}; expv = exp_vec(); n_cmp++;
        if (obs !== expv) begin n_bad++; $display("FAIL pairs cyc=%0d got=%h exp=%h", n_cyc, obs, expv); end
      end
      n_cmp++;
      if (n_acc == a0) begin n_bad++; $display("FAIL pairs_accept_timeout got=0 exp=1"); end
      inValid = 1'b0; wt = 0;
      while (busy_left > 0 && wt < 10) begin
        tick(); wt++;
        obs = {inReady, busy, outStrobes, dataOut}; expv = exp_vec(); n_cmp++;
        if (obs !== expv) begin n_bad++; $display("FAIL pairs cyc=%0d got=%h exp=%h", n_cyc, obs, expv); end
      end
      if (i == 1) begin
        wv = dataOut[2*OUT_W +: OUT_W]; n_cmp++;
        if (wv !== 16'(1)) begin n_bad++; $display("FAIL pairs_word2 got=%0d exp=1", $signed(wv)); end
      end
    end
    wv = dataOut[2*OUT_W +: OUT_W]; n_cmp++;
    if (wv !== 16'(2)) begin n_bad++; $display("FAIL pairs_word2b got=%0d exp=2", $signed(wv)); end
    wv = dataOut[1*OUT_W +: OUT_W]; n_cmp++;
    if (wv !== 16'(RND ? -2 : -3)) begin n_bad++; $display("FAIL pairs_word1 got=%0d exp=%0d", $signed(wv), RND ? -2 : -3); end
    wv = dataOut[0 +: OUT_W]; n_cmp++;
    if (wv !== 16'(RND ? 6 : 5)) begin n_bad++; $display("FAIL pairs_word0 got=%0d exp=%0d", $signed(wv), RND ? 6 : 5); end
  endtask

  task automatic test_extremes();
    int xs [2];
    int a0, wt;
    logic [OUT_W-1:0] wv;
    xs[0] = -32768; xs[1] = 32767;
    for (int i = 0; i < 2; i++) begin
      inValid = 1'b1; inData = 16'(xs[i]); a0 = n_acc; wt = 0;
      while (n_acc == a0 && wt < 10) begin
        tick(); wt++;
        obs = {inReady, busy, outStrobes, dataOut}; expv = exp_vec(); n_cmp++;
        if (obs !== expv) begin n_bad++; $display("FAIL extremes cyc=%0d got=%h exp=%h", n_cyc, obs, expv); end
      end
      n_cmp++;
      if (n_acc == a0) begin n_bad++; $display("FAIL extremes_accept_timeout got=0 exp=1"); end
      inValid = 1'b0; wt = 0;
      while (busy_left > 0 && wt < 10) begin
        tick(); wt++;
        obs = {inReady, busy, outStrobes, dataOut}; expv = exp_vec(); n_cmp++;
        if (obs !== expv) begin n_bad++; $display("FAIL extremes cyc=%0d got=%h exp=%h", n_cyc, obs, expv); end
      end
    end
    wv = dataOut[2*OUT_W +: OUT_W]; n_cmp++;
    if (wv !== 16'(RND ? -32767 : -32768)) begin
      n_bad++; $display("FAIL extremes_word2 got=%0d exp=%0d", $signed(wv), RND ? -32767 : -32768);
    end
  endtask

  task automatic test_back_to_back();
    int a0, wt, last_acc, max_iv, prev_n;
    a0 = n_acc; last_acc = -1; max_iv = 0;
    inValid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      inData = 16'($urandom); prev_n = n_acc; wt = 0;
      while (n_acc == prev_n && wt < 10) begin
        tick(); wt++;
        obs = {inReady, busy, outStrobes, dataOut}; expv = exp_vec(); n_cmp++;
        if (obs !== expv) begin n_bad++; $display("FAIL b2b cyc=%0d got=%h exp=%h", n_cyc, obs, expv); end
      end
      if (n_acc != prev_n) begin
        if (last_acc >= 0 && n_cyc - last_acc > max_iv) max_iv = n_cyc - last_acc;
        last_acc = n_cyc;
      end
    end
    inValid = 1'b0; wt = 0;
    while (busy_left > 0 && wt < 10) begin
      tick(); wt++;
      obs = {inReady, busy, outStrobes, dataOut}; expv = exp_vec(); n_cmp++;
      if (obs !== expv) begin n_bad++; $display("FAIL b2b cyc=%0d got=%h exp=%h", n_cyc, obs, expv); end
    end
    n_cmp++;
    if (n_acc - a0 != 40) begin n_bad++; $display("FAIL b2b_count got=%0d exp=40", n_acc - a0); end
    n_cmp++;
    if (max_iv != STAGES + 1) begin n_bad++; $display("FAIL b2b_max_interval got=%0d exp=%0d", max_iv, STAGES + 1); end
  endtask

  task automatic test_mid_walk_reset();
    int xs [3];
    int ys [4];
    int a0, wt;
    logic [OUT_W-1:0] wv;
    rst = 1'b1; tick(); rst = 1'b0;
    xs[0] = 4; xs[1] = 2; xs[2] = 10;
    for (int i = 0; i < 3; i++) begin
      inValid = 1'b1; inData = 16'(xs[i]); a0 = n_acc; wt = 0;
      while (n_acc == a0 && wt < 10) begin
        tick(); wt++;
        obs = {inReady, busy, outStrobes, dataOut}; expv = exp_vec(); n_cmp++;
        if (obs !== expv) begin n_bad++; $display("FAIL midrst cyc=%0d got=%h exp=%h", n_cyc, obs, expv); end
      end
      inValid = 1'b0; wt = 0;
      while (busy_left > 0 && wt < 10) begin
        tick(); wt++;
        obs = {inReady, busy, outStrobes, dataOut}; expv = exp_vec(); n_cmp++;
        if (obs !== expv) begin n_bad++; $display("FAIL midrst cyc=%0d got=%h exp=%h", n_cyc, obs, expv); end
      end
    end
    // Sample 6 completes stage 0, then reset lands on its stage-1 cycle.
    inValid = 1'b1; inData = 16'(6);
    tick();
    inValid = 1'b0;
    tick();
    obs = {inReady, busy, outStrobes, dataOut}; expv = exp_vec(); n_cmp++;
    if (obs !== expv) begin n_bad++; $display("FAIL midrst_stage0 got=%h exp=%h", obs, expv); end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (outStrobes !== '0) begin n_bad++; $display("FAIL midrst_strobe got=%b exp=000", outStrobes); end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (dataOut !== '0 || outStrobes !== '0) begin
      n_bad++; $display("FAIL midrst_clear got=%h/%b exp=0/000", dataOut, outStrobes);
    end
    ys[0] = 4; ys[1] = 2; ys[2] = 10; ys[3] = 6;
    for (int i = 0; i < 4; i++) begin
      inValid = 1'b1; inData = 16'(ys[i]); a0 = n_acc; wt = 0;
      while (n_acc == a0 && wt < 10) begin
        tick(); wt++;
        obs = {inReady, busy, outStrobes, dataOut}; expv = exp_vec(); n_cmp++;
        if (obs !== expv) begin n_bad++; $display("FAIL midrst_after cyc=%0d got=%h exp=%h", n_cyc, obs, expv); end
      end
      n_cmp++;
      if (n_acc == a0) begin n_bad++; $display("FAIL midrst_accept_timeout got=0 exp=1"); end
      inValid = 1'b0; wt = 0;
      while (busy_left > 0 && wt < 10) begin
        tick(); wt++;
        obs = {inReady, busy, outStrobes, dataOut}; expv = exp_vec(); n_cmp++;
        if (obs !== expv) begin n_bad++; $display("FAIL midrst_after cyc=%0d got=%h exp=%h", n_cyc, obs, expv); end
      end
      if (i == 1) begin
        wv = dataOut[2*OUT_W +: OUT_W]; n_cmp++;
        if (wv !== 16'(1)) begin n_bad++; $display("FAIL midrst_word2 got=%0d exp=1", $signed(wv)); end
        n_cmp++;
        if (dataOut[0 +: 2*OUT_W] !== '0) begin
          n_bad++; $display("FAIL midrst_stage1_empty got=%h exp=0", dataOut[0 +: 2*OUT_W]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      inValid = 1'($urandom_range(0, 1));
      inData  = 16'($urandom);
      tick();
      obs = {inReady, busy, outStrobes, dataOut}; expv = exp_vec(); n_cmp++;
      if (obs !== expv) begin n_bad++; $display("FAIL random cyc=%0d got=%h exp=%h", n_cyc, obs, expv); end
    end
    inValid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pairs();
    test_extremes();
    test_back_to_back();
    test_mid_walk_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
